// File: rtl/fa_check_pkg.sv
// Shared types and constants for the full-adder response checker.
// Vectors are indexed as {A,B,Cin} throughout.
package fa_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_VECTORS = 8;
  localparam logic [NUM_VECTORS-1:0] ALL_SEEN = 8'hFF;

  function automatic logic [NUM_VECTORS-1:0] vec_onehot(input logic [2:0] vec);
    logic [NUM_VECTORS-1:0] base;
    base = 8'd1;
    return base << vec;
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// Reference full adder: expected sum and carry for one applied vector.
module fa_golden_model (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s_exp,
  output logic o_cout_exp
);

  assign o_s_exp    = i_a ^ i_b ^ i_cin;
  assign o_cout_exp = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/fa_response_checker.sv
// Observes full-adder vectors and responses, compares against the golden model,
// tracks coverage of all 8 inputs and reports pass/fail, errors and the first failure.
module fa_response_checker
  import fa_check_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ERR_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             A,
  input  logic             B,
  input  logic             Cin,
  input  logic             S,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec,
  output logic [7:0]       seen_mask
);

  localparam logic [15:0]      TimeoutLimit = 16'(TIMEOUT_CYCLES);
  localparam logic [ERR_W-1:0] ErrMax       = '1;

  state_e           r_state, w_state_nxt;
  logic [15:0]      r_idle_cnt, w_idle_cnt_nxt;
  logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
  logic             r_ff_valid, w_ff_valid_nxt;
  logic [2:0]       r_ff_vec, w_ff_vec_nxt;
  logic [7:0]       r_seen, w_seen_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_busy, r_done;

  logic       w_s_exp, w_cout_exp, w_mismatch;
  logic [2:0] w_vec;
  logic [7:0] w_seen_upd;

  fa_golden_model u_golden (
    .i_a       (A),
    .i_b       (B),
    .i_cin     (Cin),
    .o_s_exp   (w_s_exp),
    .o_cout_exp(w_cout_exp)
  );

  assign w_vec      = {A, B, Cin};
  assign w_mismatch = (S != w_s_exp) || (Cout != w_cout_exp);
  assign w_seen_upd = r_seen | vec_onehot(w_vec);

  always_comb begin
    w_state_nxt     = r_state;
    w_idle_cnt_nxt  = r_idle_cnt;
    w_err_count_nxt = r_err_count;
    w_ff_valid_nxt  = r_ff_valid;
    w_ff_vec_nxt    = r_ff_vec;
    w_seen_nxt      = r_seen;
    w_timeout_nxt   = r_timeout;
    w_pass_nxt      = r_pass;

    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt     = RUN;
          w_idle_cnt_nxt  = '0;
          w_err_count_nxt = '0;
          w_ff_valid_nxt  = 1'b0;
          w_ff_vec_nxt    = '0;
          w_seen_nxt      = '0;
          w_timeout_nxt   = 1'b0;
          w_pass_nxt      = 1'b0;
        end
      end
      RUN: begin
        if (vec_valid) begin
          w_seen_nxt     = w_seen_upd;
          w_idle_cnt_nxt = '0;
          if (w_mismatch) begin
            if (r_err_count != ErrMax) begin
              w_err_count_nxt = r_err_count + ERR_W'(1);
            end
            if (!r_ff_valid) begin
              w_ff_valid_nxt = 1'b1;
              w_ff_vec_nxt   = w_vec;
            end
          end
          // The completing sample is fully accounted before pass is decoded.
          if (w_seen_upd == ALL_SEEN) begin
            w_state_nxt = DONE;
            w_pass_nxt  = (w_err_count_nxt == '0);
          end
        end else if ((r_idle_cnt + 16'd1) == TimeoutLimit) begin
          w_state_nxt   = DONE;
          w_timeout_nxt = 1'b1;
          w_pass_nxt    = 1'b0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idle_cnt  <= '0;
      r_err_count <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_vec    <= '0;
      r_seen      <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_err_count <= w_err_count_nxt;
      r_ff_valid  <= w_ff_valid_nxt;
      r_ff_vec    <= w_ff_vec_nxt;
      r_seen      <= w_seen_nxt;
      r_timeout   <= w_timeout_nxt;
      r_pass      <= w_pass_nxt;
      r_busy      <= (w_state_nxt == RUN);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign timeout          = r_timeout;
  assign err_count        = r_err_count;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;
  assign seen_mask        = r_seen;

endmodule

// File: tb/tb_fa_response_checker.sv
// Scoreboard bench: each sweep's expected result is queued at stimulus time and
// checked by a monitor when done rises.
module tb_fa_response_checker;

  localparam int T       = 16;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = 15;

  typedef struct {
    bit       v;
    bit       st;
    bit [2:0] vec;
    bit       s;
    bit       co;
  } ent_t;

  typedef struct {
    int       cycle;
    bit       pass;
    bit       timeout;
    int       err;
    bit       ffv;
    bit [2:0] ffvec;
    bit [7:0] seen;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, vec_valid = 1'b0;
  logic A = 1'b0, B = 1'b0, Cin = 1'b0, S = 1'b0, Cout = 1'b0;
  logic busy, done, pass, timeout, first_fail_valid;
  logic [ERR_W-1:0] err_count;
  logic [2:0] first_fail_vec;
  logic [7:0] seen_mask;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got;
  bit   prev_done = 1'b0;

  fa_response_checker #(
    .TIMEOUT_CYCLES(T),
    .ERR_W         (ERR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .vec_valid       (vec_valid),
    .A               (A),
    .B               (B),
    .Cin             (Cin),
    .S               (S),
    .Cout            (Cout),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .err_count       (err_count),
    .first_fail_valid(first_fail_valid),
    .first_fail_vec  (first_fail_vec),
    .seen_mask       (seen_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Correct adder response for vec, optionally corrupted.
  function automatic ent_t mk(input bit v, input bit [2:0] vec, input bit fs, input bit fc,
                              input bit st);
    ent_t e;
    int   ones;
    ones   = int'(vec[0]) + int'(vec[1]) + int'(vec[2]);
    e.v    = v;
    e.st   = st;
    e.vec  = vec;
    e.s    = bit'(ones % 2) ^ fs;
    e.co   = (ones >= 2) ^ fc;
    return e;
  endfunction

  // Outcome of a sweep from the checker's rules: coverage set, error tally, idle limit.
  function automatic void model(input ent_t q[$], output exp_t e, output int n_used,
                                output int offset);
    bit cov[8];
    int ncov, errs, idle, ones;
    bit fin, tmo, ok;
    ncov = 0; errs = 0; idle = 0; fin = 0; tmo = 0;
    e.ffv = 0; e.ffvec = 0; e.cycle = 0;
    foreach (cov[k]) cov[k] = 0;
    n_used = q.size();
    offset = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].v) begin
        ones = $countones(q[i].vec);
        ok   = (int'(q[i].s) == ones % 2) && (q[i].co == (ones >= 2));
        if (!ok) begin
          if (errs < ERR_MAX) errs++;
          if (!e.ffv) begin
            e.ffv   = 1;
            e.ffvec = q[i].vec;
          end
        end
        if (!cov[q[i].vec]) begin
          cov[q[i].vec] = 1;
          ncov++;
        end
        idle = 0;
        if (ncov == 8) begin
          fin = 1; n_used = i + 1; offset = i + 1;
          break;
        end
      end else begin
        idle++;
        if (idle == T) begin
          fin = 1; tmo = 1; n_used = i + 1; offset = i + 1;
          break;
        end
      end
    end
    if (!fin) begin
      tmo    = 1;
      offset = q.size() + (T - idle);
    end
    e.timeout = tmo;
    e.err     = errs;
    e.pass    = !tmo && errs == 0;
    for (int k = 0; k < 8; k++) e.seen[k] = cov[k];
  endfunction

  // Called #1 after a rising edge.
  task automatic run_sweep(input ent_t q[$]);
    exp_t e;
    int   n, off;
    model(q, e, n, off);
    start   = 1;
    e.cycle = cyc + 1 + off;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 0;
    chk("start_busy", int'(busy), 1);
    chk("start_done_clr", int'(done), 0);
    chk("start_seen_clr", int'(seen_mask), 0);
    chk("start_err_clr", int'(err_count), 0);
    chk("start_pass_clr", int'(pass), 0);
    chk("start_tmo_clr", int'(timeout), 0);
    chk("start_ffv_clr", int'(first_fail_valid), 0);
    for (int i = 0; i < n; i++) begin
      vec_valid = q[i].v;
      {A, B, Cin} = q[i].vec;
      S = q[i].s;
      Cout = q[i].co;
      start = q[i].st;
      @(posedge clk); #1;
    end
    vec_valid = 0;
    start = 0;
    for (int k = 0; k < T + 8 && !done; k++) begin
      @(posedge clk); #1;
    end
    chk("done_wait", int'(done), 1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  ent_t q[$];
  int   excl;
  bit [2:0] rv;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (done && !prev_done) begin
          if (sb.size() == 0) begin
            chk("spurious_done", int'(done), 0);
          end else begin
            got = sb.pop_front();
            chk("done_cycle", cyc, got.cycle);
            chk("pass", int'(pass), int'(got.pass));
            chk("timeout", int'(timeout), int'(got.timeout));
            chk("err_count", int'(err_count), got.err);
            chk("ff_valid", int'(first_fail_valid), int'(got.ffv));
            if (got.ffv) chk("ff_vec", int'(first_fail_vec), int'(got.ffvec));
            chk("seen_mask", int'(seen_mask), int'(got.seen));
            chk("busy_in_done", int'(busy), 0);
          end
        end
        prev_done = done;
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_ffv", int'(first_fail_valid), 0);
    chk("rst_ffvec", int'(first_fail_vec), 0);
    chk("rst_seen", int'(seen_mask), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Samples before any start are ignored
    vec_valid = 1; {A, B, Cin} = 3'b011; S = 1; Cout = 0;
    @(posedge clk); #1;
    vec_valid = 0;
    chk("idle_ignore_seen", int'(seen_mask), 0);
    chk("idle_ignore_err", int'(err_count), 0);

    // Full correct sweep
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(1, 3'(i), 0, 0, 0));
    run_sweep(q);

    // S wrong on 101, Cout wrong on 110
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(1, 3'(i), i == 5, i == 6, 0));
    run_sweep(q);

    // Missing 110 -> timeout, seen 8'hBF
    q.delete();
    for (int i = 0; i < 8; i++) if (i != 6) q.push_back(mk(1, 3'(i), 0, 0, 0));
    run_sweep(q);

    // Saturating error counter
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(mk(1, 3'b000, 1, 0, 0));
    for (int i = 1; i < 8; i++) q.push_back(mk(1, 3'(i), 0, 0, 0));
    run_sweep(q);

    // start pulses mid-RUN are ignored
    q.delete();
    for (int i = 0; i < 8; i++) begin
      q.push_back(mk(1, 3'(7 - i), 0, 0, i == 2 || i == 5));
      if (i == 3) q.push_back(mk(0, 3'b000, 0, 0, 1));
    end
    run_sweep(q);

    // Asynchronous reset mid-sweep
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 4; i++) begin
      vec_valid = 1; {A, B, Cin} = 3'(i); S = 1; Cout = 1;
      @(posedge clk); #1;
    end
    vec_valid = 0;
    chk("pre_rst_seen", int'(seen_mask), 8'h0F);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_pass", int'(pass), 0);
    chk("arst_timeout", int'(timeout), 0);
    chk("arst_err", int'(err_count), 0);
    chk("arst_ffv", int'(first_fail_valid), 0);
    chk("arst_ffvec", int'(first_fail_vec), 0);
    chk("arst_seen", int'(seen_mask), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      vec_valid = 1; {A, B, Cin} = 3'(i + 4); S = 0; Cout = 0;
      @(posedge clk); #1;
    end
    vec_valid = 0;
    chk("post_rst_seen", int'(seen_mask), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_err", int'(err_count), 0);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(1, 3'(i), 0, 0, 0));
    run_sweep(q);

    // Randomized sweeps
    for (int s = 0; s < 24; s++) begin
      q.delete();
      excl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      for (int i = 0; i < int'($urandom_range(8, 40)); i++) begin
        rv = 3'($urandom_range(0, 7));
        if (int'(rv) == excl) rv = rv + 3'd1;
        q.push_back(mk($urandom_range(0, 4) != 0, rv, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0));
      end
      run_sweep(q);
    end

    chk("pending_expect", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
